// File: rtl/gfx_pkg.sv
// Shared pixel-word layout and helpers for the display path.
// Pixel word is {r, g, b, valid} with valid in bit 0.
package gfx_pkg;

    localparam int CW        = 8;
    localparam int PW        = 3 * CW + 1;
    localparam int VALID_OFS = 0;
    localparam int B_OFS     = 1;
    localparam int G_OFS     = B_OFS + CW;
    localparam int R_OFS     = G_OFS + CW;

    localparam logic [2:0] HIT_NONE = 3'd7;

    typedef enum logic [1:0] {
        BG_CHECKER     = 2'd0,
        BG_BLACK       = 2'd1,
        BG_SOLID       = 2'd2,
        BG_INV_CHECKER = 2'd3
    } bg_mode_t;

    function automatic logic [PW-1:0] pack_pixel(input logic [CW-1:0] r,
                                                 input logic [CW-1:0] g,
                                                 input logic [CW-1:0] b,
                                                 input logic          valid);
        logic [PW-1:0] p;
        p                = '0;
        p[R_OFS +: CW]   = r;
        p[G_OFS +: CW]   = g;
        p[B_OFS +: CW]   = b;
        p[VALID_OFS]     = valid;
        return p;
    endfunction

    function automatic logic [3*CW-1:0] pixel_rgb(input logic [PW-1:0] p);
        return {p[R_OFS +: CW], p[G_OFS +: CW], p[B_OFS +: CW]};
    endfunction

    function automatic logic pixel_valid(input logic [PW-1:0] p);
        return p[VALID_OFS];
    endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Lowest-index-first priority encoder with any/multiple-request flags.
module layer_priority_enc
    import gfx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         any,
    output logic         multi
);

    always_comb begin
        idx   = HIT_NONE;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    idx = 3'(i);
                end
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite-layer compositor with frame-shadowed controls and
// per-frame collision reporting.
module layer_compositor
    import gfx_pkg::*;
#(
    parameter int              NUM_LAYERS  = 4,
    parameter int              COL_W       = 12,
    parameter int              ROW_W       = 11,
    parameter int              CHECKER_BIT = 7,
    parameter logic [CW-1:0]   BG_LEVEL    = 8'h1F,
    parameter logic [3*CW-1:0] BG_COLOR    = 24'h000040
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_LAYERS*PW-1:0]   layer_color,
    input  logic [COL_W-1:0]           display_col,
    input  logic [ROW_W-1:0]           display_row,
    input  logic                       visible,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic [NUM_LAYERS-1:0]      layer_enable,
    input  logic [1:0]                 bg_mode,
    output logic [CW-1:0]              vga_r,
    output logic [CW-1:0]              vga_g,
    output logic [CW-1:0]              vga_b,
    output logic                       vga_hs,
    output logic                       vga_vs,
    output logic                       vga_blank_n,
    output logic [2:0]                 hit_layer,
    output logic [NUM_LAYERS-1:0]      collision_status,
    output logic                       collision_valid
);

    logic [NUM_LAYERS*PW-1:0] s1_color;
    logic                     s1_visible, s1_hs, s1_vs, s1_vs_d, s1_chk;
    logic [NUM_LAYERS-1:0]    s1_valid, active, frame_hits, en_shadow, accum;
    bg_mode_t                 bgm_shadow;
    logic [2:0]               win_idx;
    logic                     win_any, win_multi, frame_edge;
    logic [3*CW-1:0]          win_rgb, bg_rgb;
    logic                     unused_pos;

    // Only the checker bit of the position is needed.
    assign unused_pos = ^{display_col, display_row};

    always_comb begin
        s1_valid = '0;
        win_rgb  = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            s1_valid[i] = pixel_valid(s1_color[i*PW +: PW]);
            if (win_idx == 3'(i)) win_rgb = pixel_rgb(s1_color[i*PW +: PW]);
        end
    end

    assign active     = s1_valid & en_shadow;
    assign frame_edge = s1_vs_d & ~s1_vs;
    assign frame_hits = (s1_visible && win_multi) ? active : '0;

    layer_priority_enc #(.N(NUM_LAYERS)) u_enc (
        .req   (active),
        .idx   (win_idx),
        .any   (win_any),
        .multi (win_multi)
    );

    always_comb begin
        bg_rgb = '0;
        case (bgm_shadow)
            BG_CHECKER:     bg_rgb = s1_chk ? {3{BG_LEVEL}} : '0;
            BG_INV_CHECKER: bg_rgb = s1_chk ? '0 : {3{BG_LEVEL}};
            BG_SOLID:       bg_rgb = BG_COLOR;
            default:        bg_rgb = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_color   <= '0;
            s1_visible <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_vs_d    <= 1'b1;
            s1_chk     <= 1'b0;
        end else begin
            s1_color   <= layer_color;
            s1_visible <= visible;
            s1_hs      <= hsync;
            s1_vs      <= vsync;
            s1_vs_d    <= s1_vs;
            s1_chk     <= display_col[CHECKER_BIT] ^ display_row[CHECKER_BIT];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {vga_r, vga_g, vga_b} <= '0;
            hit_layer             <= HIT_NONE;
            vga_hs                <= 1'b1;
            vga_vs                <= 1'b1;
            vga_blank_n           <= 1'b0;
        end else begin
            if (!s1_visible) begin
                {vga_r, vga_g, vga_b} <= '0;
                hit_layer             <= HIT_NONE;
            end else if (win_any) begin
                {vga_r, vga_g, vga_b} <= win_rgb;
                hit_layer             <= win_idx;
            end else begin
                {vga_r, vga_g, vga_b} <= bg_rgb;
                hit_layer             <= HIT_NONE;
            end
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vga_blank_n <= s1_hs & s1_vs;
        end
    end

    // Boundary-cycle hits belong to the frame that is just starting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_shadow        <= '1;
            bgm_shadow       <= BG_CHECKER;
            accum            <= '0;
            collision_status <= '0;
            collision_valid  <= 1'b0;
        end else if (frame_edge) begin
            en_shadow        <= layer_enable;
            bgm_shadow       <= bg_mode_t'(bg_mode);
            accum            <= frame_hits;
            collision_status <= accum;
            collision_valid  <= 1'b1;
        end else begin
            accum            <= accum | frame_hits;
            collision_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed vector table plus randomized frames against a frame-level reference model.
module tb_layer_compositor;
    import gfx_pkg::*;

    localparam int N  = 4;
    localparam int LW = N * PW;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [LW-1:0]   layer_color;
    logic [11:0]     display_col;
    logic [10:0]     display_row;
    logic            visible, hsync, vsync;
    logic [N-1:0]    layer_enable;
    logic [1:0]      bg_mode;
    logic [7:0]      vga_r, vga_g, vga_b;
    logic            vga_hs, vga_vs, vga_blank_n;
    logic [2:0]      hit_layer;
    logic [N-1:0]    collision_status;
    logic            collision_valid;

    always #5 clock = ~clock;

    layer_compositor dut (
        .clock            (clock),
        .reset            (reset),
        .layer_color      (layer_color),
        .display_col      (display_col),
        .display_row      (display_row),
        .visible          (visible),
        .hsync            (hsync),
        .vsync            (vsync),
        .layer_enable     (layer_enable),
        .bg_mode          (bg_mode),
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .vga_hs           (vga_hs),
        .vga_vs           (vga_vs),
        .vga_blank_n      (vga_blank_n),
        .hit_layer        (hit_layer),
        .collision_status (collision_status),
        .collision_valid  (collision_valid)
    );

    typedef struct packed {
        logic [LW-1:0] lc;
        logic          vis, hs, vs;
        logic [N-1:0]  en;
        logic [1:0]    bgm;
        logic [11:0]   col;
        logic [10:0]   row;
    } vec_t;

    typedef struct packed {
        logic [23:0]  rgb;
        logic [2:0]   hit;
        logic         hs, vs, blank;
        logic [N-1:0] status;
        logic         cval;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } rec_t;

    rec_t   tbl[$];
    exp_t   pend[$];
    int     errors = 0;
    int     checks = 0;
    string  phase;

    // reference model state
    logic [N-1:0] m_en, m_acc, m_status;
    logic [1:0]   m_bgm;
    bit           m_pending, m_prev_vs;
    int           fpos, flen;
    logic [N-1:0] cur_en;
    logic [1:0]   cur_bgm;

    function automatic logic [23:0] pal(input int i);
        case (i)
            0:       return 24'h00FF00;
            1:       return 24'hFF0000;
            2:       return 24'h0000FF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic vec_t mkvec(input logic [N-1:0] lv, input logic vis, hs, vs,
                                   input logic [N-1:0] en, input logic [1:0] bgm,
                                   input int col, input int row);
        vec_t v;
        for (int i = 0; i < N; i++) v.lc[i*PW +: PW] = {pal(i), lv[i]};
        v.vis = vis; v.hs = hs; v.vs = vs; v.en = en; v.bgm = bgm;
        v.col = 12'(col); v.row = 11'(row);
        return v;
    endfunction

    function automatic exp_t mkexp(input logic [23:0] rgb, input logic [2:0] hit,
                                   input vec_t v, input logic [N-1:0] st, input logic cv);
        exp_t e;
        e.rgb = rgb; e.hit = hit; e.hs = v.hs; e.vs = v.vs; e.blank = v.hs & v.vs;
        e.status = st; e.cval = cv;
        return e;
    endfunction

    task automatic add(input vec_t v, input logic [23:0] rgb, input logic [2:0] hit,
                       input logic [N-1:0] st, input logic cv);
        rec_t r;
        r.v = v;
        r.e = mkexp(rgb, hit, v, st, cv);
        tbl.push_back(r);
    endtask

    task automatic model_reset();
        m_en = '1; m_bgm = 2'd0; m_acc = '0; m_status = '0;
        m_pending = 1'b0; m_prev_vs = 1'b1;
    endtask

    // One pixel through the compositor, at frame granularity: controls latch
    // at the pixel following a vsync fall, collisions OR per frame.
    task automatic model_step(input vec_t v, output exp_t e);
        logic [N-1:0] act, hits;
        logic [23:0]  rgb;
        logic [2:0]   hit;
        logic         chk;
        int           win, cnt;
        if (m_pending) begin
            m_en = v.en; m_bgm = v.bgm; m_pending = 1'b0;
        end
        win = -1; cnt = 0;
        for (int i = 0; i < N; i++) begin
            act[i] = v.lc[i*PW] & m_en[i];
            if (act[i]) begin
                cnt++;
                if (win < 0) win = i;
            end
        end
        chk = v.col[7] ^ v.row[7];
        if (!v.vis) begin
            rgb = 24'h0; hit = 3'd7;
        end else if (win >= 0) begin
            rgb = v.lc[win*PW + 1 +: 24]; hit = 3'(win);
        end else begin
            hit = 3'd7;
            case (m_bgm)
                2'd0:    rgb = chk ? 24'h1F1F1F : 24'h0;
                2'd2:    rgb = 24'h000040;
                2'd3:    rgb = chk ? 24'h0 : 24'h1F1F1F;
                default: rgb = 24'h0;
            endcase
        end
        hits = (v.vis && cnt >= 2) ? act : '0;
        if (m_prev_vs && !v.vs) begin
            m_status  = m_acc;
            m_acc     = hits;
            m_pending = 1'b1;
            e = mkexp(rgb, hit, v, m_status, 1'b1);
        end else begin
            m_acc = m_acc | hits;
            e = mkexp(rgb, hit, v, m_status, 1'b0);
        end
        m_prev_vs = v.vs;
    endtask

    task automatic drive(input vec_t v);
        layer_color  = v.lc;
        visible      = v.vis;
        hsync        = v.hs;
        vsync        = v.vs;
        layer_enable = v.en;
        bg_mode      = v.bgm;
        display_col  = v.col;
        display_row  = v.row;
    endtask

    task automatic check_out(input exp_t x);
        exp_t a;
        a.rgb = {vga_r, vga_g, vga_b}; a.hit = hit_layer; a.hs = vga_hs; a.vs = vga_vs;
        a.blank = vga_blank_n; a.status = collision_status; a.cval = collision_valid;
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s chk%0d: got rgb=%h hit=%0d hs=%b vs=%b bl=%b st=%b cv=%b, want rgb=%h hit=%0d hs=%b vs=%b bl=%b st=%b cv=%b",
                     phase, checks, a.rgb, a.hit, a.hs, a.vs, a.blank, a.status, a.cval,
                     x.rgb, x.hit, x.hs, x.vs, x.blank, x.status, x.cval);
        end
    endtask

    // Inputs are driven 1 ns after an edge; outputs for them appear two edges later.
    task automatic step(input exp_t e);
        pend.push_back(e);
        @(posedge clock);
        #1;
        if (pend.size() >= 2) check_out(pend.pop_front());
    endtask

    task automatic run_model(input vec_t v);
        exp_t e;
        model_step(v, e);
        drive(v);
        step(e);
    endtask

    task automatic gen_vec(input bit stuck_vs, output vec_t v);
        for (int i = 0; i < N; i++)
            v.lc[i*PW +: PW] = {24'($urandom), 1'($urandom_range(0, 1))};
        v.vis = ($urandom_range(0, 3) != 0);
        v.hs  = ($urandom_range(0, 7) != 0);
        if (stuck_vs) begin
            v.vs = 1'b1;
        end else begin
            v.vs = (fpos >= 2);
            fpos++;
            if (fpos >= flen) begin
                fpos = 0;
                flen = $urandom_range(6, 16);
            end
        end
        if ($urandom_range(0, 5) == 0) cur_en = 4'($urandom);
        if ($urandom_range(0, 5) == 0) cur_bgm = 2'($urandom);
        v.en = cur_en; v.bgm = cur_bgm;
        v.col = 12'($urandom); v.row = 11'($urandom);
    endtask

    initial begin
        exp_t rst_exp, dummy;
        vec_t idle, v;

        idle = mkvec(4'b0000, 1'b0, 1'b1, 1'b1, 4'hF, 2'd0, 0, 0);
        rst_exp = '{rgb: 24'h0, hit: 3'd7, hs: 1'b1, vs: 1'b1, blank: 1'b0,
                    status: '0, cval: 1'b0};

        //   lv       vis   hs    vs    en    bgm  col  row     rgb        hit   status   cv
        add(mkvec(4'b0000, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 128, 0),   24'h1F1F1F, 3'd7, 4'b0000, 1'b0);
        add(mkvec(4'b0110, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 0,   0),   24'hFF0000, 3'd1, 4'b0000, 1'b0);
        add(mkvec(4'b0110, 1'b1, 1'b1, 1'b1, 4'hD, 2'd0, 0,   0),   24'hFF0000, 3'd1, 4'b0000, 1'b0);
        add(mkvec(4'b1001, 1'b1, 1'b1, 1'b0, 4'hD, 2'd0, 0,   0),   24'h00FF00, 3'd0, 4'b0110, 1'b1);
        add(mkvec(4'b0110, 1'b1, 1'b1, 1'b0, 4'hD, 2'd0, 0,   0),   24'h0000FF, 3'd2, 4'b0110, 1'b0);
        add(mkvec(4'b0110, 1'b1, 1'b1, 1'b1, 4'hD, 2'd0, 0,   0),   24'h0000FF, 3'd2, 4'b0110, 1'b0);
        add(mkvec(4'b0000, 1'b1, 1'b1, 1'b0, 4'hD, 2'd2, 0,   0),   24'h000000, 3'd7, 4'b1001, 1'b1);
        add(mkvec(4'b0000, 1'b1, 1'b1, 1'b0, 4'hD, 2'd2, 0,   0),   24'h000040, 3'd7, 4'b1001, 1'b0);
        add(mkvec(4'b0001, 1'b0, 1'b0, 1'b1, 4'hD, 2'd2, 0,   0),   24'h000000, 3'd7, 4'b1001, 1'b0);
        add(mkvec(4'b0001, 1'b1, 1'b1, 1'b1, 4'hD, 2'd3, 128, 128), 24'h00FF00, 3'd0, 4'b1001, 1'b0);
        add(mkvec(4'b0000, 1'b1, 1'b1, 1'b0, 4'hD, 2'd3, 0,   0),   24'h000040, 3'd7, 4'b0000, 1'b1);
        add(mkvec(4'b0000, 1'b1, 1'b1, 1'b0, 4'hD, 2'd3, 128, 0),   24'h000000, 3'd7, 4'b0000, 1'b0);
        add(mkvec(4'b0000, 1'b1, 1'b1, 1'b1, 4'hD, 2'd3, 0,   0),   24'h1F1F1F, 3'd7, 4'b0000, 1'b0);

        drive(idle);
        #12;
        phase = "power_on_reset";
        check_out(rst_exp);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        phase = "directed";
        foreach (tbl[i]) begin
            model_step(tbl[i].v, dummy);
            drive(tbl[i].v);
            step(tbl[i].e);
        end

        phase = "random";
        fpos = 2; flen = 10; cur_en = 4'hF; cur_bgm = 2'd0;
        repeat (800) begin
            gen_vec(1'b0, v);
            run_model(v);
        end

        phase = "vsync_stuck";
        repeat (60) begin
            gen_vec(1'b1, v);
            run_model(v);
        end

        phase = "pre_reset_collide";
        repeat (4) run_model(mkvec(4'b1111, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 0, 0));

        phase = "async_reset";
        #2;
        reset = 1'b0;
        #1;
        check_out(rst_exp);
        pend.delete();
        model_reset();
        drive(idle);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        phase = "post_reset_frame";
        repeat (4) run_model(mkvec(4'b0001, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 0, 0));
        repeat (2) run_model(mkvec(4'b0000, 1'b1, 1'b1, 1'b0, 4'hF, 2'd0, 0, 0));
        repeat (3) run_model(mkvec(4'b0011, 1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 0, 0));
        repeat (2) run_model(mkvec(4'b0000, 1'b1, 1'b1, 1'b0, 4'hF, 2'd0, 0, 0));
        run_model(idle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
